// File: rtl/banked_ram_mmio.sv
// Byte-lane banked RAM with registered data and fetch read ports, one byte-enabled write port,
// and a console MMIO word whose writes feed a TX FIFO drained as a ready/valid byte stream.
module banked_ram_mmio #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int CONSOLE_ADDR   = 128,
    parameter int CON_FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_read_req,
    input  logic [ADDR_WIDTH-1:0]   i_read_addr,
    output logic                    o_read_valid,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    input  logic                    i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]   i_fetch_addr,
    output logic                    o_fetch_valid,
    output logic [DATA_WIDTH-1:0]   o_fetch_data,
    input  logic                    i_write_enable,
    input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
    input  logic [ADDR_WIDTH-1:0]   i_write_addr,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    output logic                    o_write_ready,
    output logic                    o_con_valid,
    output logic [7:0]              o_con_data,
    input  logic                    i_con_ready,
    output logic                    o_addr_fault
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(CON_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] CON_A   = ADDR_WIDTH'(CONSOLE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         con_count;
    logic [CW-1:0]         count_next;
    logic                  con_full;
    logic [7:0]            fifo_mem [CON_FIFO_DEPTH];
    logic [7:0]            head_next;
    logic                  w_accept;
    logic                  store_we;
    logic                  push;
    logic                  pop;
    logic                  fault_next;
    logic [DATA_WIDTH-1:0] read_old;
    logic [DATA_WIDTH-1:0] fetch_old;
    logic [DATA_WIDTH-1:0] read_next;
    logic [DATA_WIDTH-1:0] fetch_next;
    logic [DATA_WIDTH-1:0] status_word;

    function automatic logic in_store(input logic [ADDR_WIDTH-1:0] a);
        return (a < DEPTH_A) && (a != CON_A);
    endfunction

    function automatic logic is_fault(input logic [ADDR_WIDTH-1:0] a);
        return (a >= DEPTH_A) && (a != CON_A);
    endfunction

    // Write-first merge: a read of the word being written sees enabled lanes with the new byte.
    function automatic logic [DATA_WIDTH-1:0] port_word(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] status,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [NB-1:0]         be,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        if (a == CON_A) begin
            w = status;
        end else if (in_store(a)) begin
            w = old;
            if (we && (a == waddr)) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end
        return w;
    endfunction

    assign o_write_ready = ~con_full;
    assign o_con_valid   = (con_count != '0);
    assign status_word   = {{(DATA_WIDTH-CW-1){1'b0}}, con_full, con_count};

    assign w_accept   = i_write_enable & o_write_ready & clk_en;
    assign store_we   = w_accept & in_store(i_write_addr);
    assign push       = w_accept & (i_write_addr == CON_A) & i_byte_enable[0];
    assign pop        = o_con_valid & i_con_ready & clk_en;
    assign count_next = con_count + CW'(push) - CW'(pop);
    assign fault_next = (i_read_req & is_fault(i_read_addr)) | (i_fetch_req & is_fault(i_fetch_addr))
                      | (w_accept & is_fault(i_write_addr));

    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [7:0] bank [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (store_we && i_byte_enable[k]) bank[i_write_addr[IW-1:0]] <= i_write_data[8*k +: 8];
        end

        assign read_old[8*k +: 8]  = bank[i_read_addr[IW-1:0]];
        assign fetch_old[8*k +: 8] = bank[i_fetch_addr[IW-1:0]];
    end

    always_comb begin
        read_next  = port_word(i_read_addr, read_old, status_word, store_we, i_write_addr,
                               i_byte_enable, i_write_data);
        fetch_next = port_word(i_fetch_addr, fetch_old, status_word, store_we, i_write_addr,
                               i_byte_enable, i_write_data);
    end

    // Next registered FIFO head: a push into an empty (or emptying) FIFO becomes the head directly.
    always_comb begin
        head_next = o_con_data;
        if (count_next == '0) begin
            head_next = '0;
        end else if ((con_count == '0) || (pop && (con_count == CW'(1)))) begin
            head_next = i_write_data[7:0];
        end else if (pop) begin
            head_next = fifo_mem[rd_ptr + PW'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= i_write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_read_valid  <= 1'b0;
            o_read_data   <= '0;
            o_fetch_valid <= 1'b0;
            o_fetch_data  <= '0;
            o_addr_fault  <= 1'b0;
            o_con_data    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            con_count     <= '0;
            con_full      <= 1'b0;
        end else if (clk_en) begin
            o_read_valid  <= i_read_req;
            o_fetch_valid <= i_fetch_req;
            if (i_read_req)  o_read_data  <= read_next;
            if (i_fetch_req) o_fetch_data <= fetch_next;
            o_addr_fault  <= fault_next;
            o_con_data    <= head_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            con_count     <= count_next;
            con_full      <= (count_next == CW'(CON_FIFO_DEPTH));
        end
    end
endmodule
